// File: rtl/rgb_to_yuv_downsampler_pkg.sv
// Shared state enum, colour-space coefficients and small arithmetic helpers
// for the RGB-to-YUV compression path.
package rgb_to_yuv_downsampler_pkg;

    typedef enum logic [2:0] {
        S_RGB_IDLE,
        S_RGB_READ,
        S_RGB_WAIT,
        S_RGB_COMPUTE,
        S_RGB_WRITE,
        S_RGB_DONE
    } rgb_to_yuv_state_type;

    localparam int signed C_Y_R   = 16843;
    localparam int signed C_Y_G   = 33030;
    localparam int signed C_Y_B   = 6423;
    localparam int signed C_U_R   = -9699;
    localparam int signed C_U_G   = -19071;
    localparam int signed C_U_B   = 28770;
    localparam int signed C_V_R   = 28770;
    localparam int signed C_V_G   = -24117;
    localparam int signed C_V_B   = -4653;
    localparam int signed C_ROUND = 32768;
    localparam int signed C_Y_OFS = 16;
    localparam int signed C_C_OFS = 128;

    // Three-product multiply-accumulate with the rounding constant folded in.
    function automatic logic signed [31:0] mac3(input int signed c0, input int signed c1,
                                                input int signed c2, input logic [7:0] r,
                                                input logic [7:0] g, input logic [7:0] b);
        return c0 * $signed({24'd0, r}) + c1 * $signed({24'd0, g})
             + c2 * $signed({24'd0, b}) + C_ROUND;
    endfunction

    function automatic logic [7:0] clip_u8(input logic signed [31:0] x);
        if (x < 0) begin
            return 8'd0;
        end else if (x > 255) begin
            return 8'd255;
        end
        return x[7:0];
    endfunction

    function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + 9'd1;
        return s[8:1];
    endfunction

endpackage

// File: rtl/yuv_pixel_converter.sv
// Combinational RGB-to-YUV conversion of one pixel, each component clipped
// to 8 bits.
module yuv_pixel_converter
    import rgb_to_yuv_downsampler_pkg::*;
(
    input  logic [7:0] i_r,
    input  logic [7:0] i_g,
    input  logic [7:0] i_b,
    output logic [7:0] o_y,
    output logic [7:0] o_u,
    output logic [7:0] o_v
);

    logic signed [31:0] w_y_acc;
    logic signed [31:0] w_u_acc;
    logic signed [31:0] w_v_acc;

    always_comb begin
        // Arithmetic shift gives floor division for negative chroma sums.
        w_y_acc = mac3(C_Y_R, C_Y_G, C_Y_B, i_r, i_g, i_b) >>> 16;
        w_u_acc = mac3(C_U_R, C_U_G, C_U_B, i_r, i_g, i_b) >>> 16;
        w_v_acc = mac3(C_V_R, C_V_G, C_V_B, i_r, i_g, i_b) >>> 16;
        o_y     = clip_u8(w_y_acc + C_Y_OFS);
        o_u     = clip_u8(w_u_acc + C_C_OFS);
        o_v     = clip_u8(w_v_acc + C_C_OFS);
    end

endmodule

// File: rtl/rgb_to_yuv_downsampler.sv
// Reads packed RGB from SRAM in groups of 4 pixels, converts to YUV, halves
// chroma horizontally and writes the Y, U and V planes back.
module rgb_to_yuv_downsampler #(
    parameter int unsigned RGB_BASE   = 146944,
    parameter int unsigned Y_BASE     = 0,
    parameter int unsigned U_BASE     = 38400,
    parameter int unsigned V_BASE     = 57600,
    parameter int unsigned NUM_PIXELS = 76800
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Enable,
    output logic        Done,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n
);

    import rgb_to_yuv_downsampler_pkg::*;

    localparam logic [17:0] RgbBase   = 18'(RGB_BASE);
    localparam logic [17:0] YBase     = 18'(Y_BASE);
    localparam logic [17:0] UBase     = 18'(U_BASE);
    localparam logic [17:0] VBase     = 18'(V_BASE);
    localparam logic [17:0] LastGroup = 18'(NUM_PIXELS / 4 - 1);

    rgb_to_yuv_state_type r_state;
    logic [2:0]  r_step;
    logic [17:0] r_group;
    logic [17:0] r_rgb_ptr;
    logic [17:0] r_y_ptr;
    logic [17:0] r_c_off;
    logic [15:0] r_buf [6];
    logic [7:0]  r_y [4];
    logic [7:0]  r_u [4];
    logic [7:0]  r_v [4];
    logic [17:0] r_address;
    logic [15:0] r_wdata;
    logic        r_we_n;
    logic        r_done;

    logic [7:0] w_r, w_g, w_b;
    logic [7:0] w_y, w_u, w_v;

    // Pixel selector over the 6-word buffer: two pixels per three words.
    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        unique case (r_step[1:0])
            2'd0: begin
                {w_r, w_g} = r_buf[0];
                w_b        = r_buf[1][15:8];
            end
            2'd1: begin
                w_r        = r_buf[1][7:0];
                {w_g, w_b} = r_buf[2];
            end
            2'd2: begin
                {w_r, w_g} = r_buf[3];
                w_b        = r_buf[4][15:8];
            end
            2'd3: begin
                w_r        = r_buf[4][7:0];
                {w_g, w_b} = r_buf[5];
            end
        endcase
    end

    yuv_pixel_converter u_conv (
        .i_r (w_r),
        .i_g (w_g),
        .i_b (w_b),
        .o_y (w_y),
        .o_u (w_u),
        .o_v (w_v)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state   <= S_RGB_IDLE;
            r_step    <= '0;
            r_group   <= '0;
            r_rgb_ptr <= '0;
            r_y_ptr   <= '0;
            r_c_off   <= '0;
            r_address <= '0;
            r_wdata   <= '0;
            r_we_n    <= 1'b1;
            r_done    <= 1'b0;
            for (int i = 0; i < 6; i++) r_buf[i] <= '0;
            for (int i = 0; i < 4; i++) begin
                r_y[i] <= '0;
                r_u[i] <= '0;
                r_v[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_RGB_IDLE: begin
                    if (Enable) begin
                        r_group   <= '0;
                        r_rgb_ptr <= RgbBase;
                        r_y_ptr   <= YBase;
                        r_c_off   <= '0;
                        r_address <= RgbBase;
                        r_step    <= '0;
                        r_state   <= S_RGB_READ;
                    end
                end
                S_RGB_READ: begin
                    // Data arrives two cycles behind its address.
                    if (r_step >= 3'd2) r_buf[r_step - 3'd2] <= SRAM_read_data;
                    r_step <= r_step + 3'd1;
                    if (r_step == 3'd5) begin
                        r_state <= S_RGB_WAIT;
                    end else begin
                        r_address <= r_address + 18'd1;
                    end
                end
                S_RGB_WAIT: begin
                    r_buf[r_step - 3'd2] <= SRAM_read_data;
                    r_step <= r_step + 3'd1;
                    if (r_step == 3'd7) begin
                        r_step  <= '0;
                        r_state <= S_RGB_COMPUTE;
                    end
                end
                S_RGB_COMPUTE: begin
                    r_y[r_step[1:0]] <= w_y;
                    r_u[r_step[1:0]] <= w_u;
                    r_v[r_step[1:0]] <= w_v;
                    r_step <= r_step + 3'd1;
                    if (r_step == 3'd3) begin
                        r_step    <= '0;
                        r_address <= r_y_ptr;
                        r_wdata   <= {r_y[0], r_y[1]};
                        r_we_n    <= 1'b0;
                        r_state   <= S_RGB_WRITE;
                    end
                end
                S_RGB_WRITE: begin
                    r_step <= r_step + 3'd1;
                    unique case (r_step[1:0])
                        2'd0: begin
                            r_address <= r_y_ptr + 18'd1;
                            r_wdata   <= {r_y[2], r_y[3]};
                        end
                        2'd1: begin
                            r_address <= UBase + r_c_off;
                            r_wdata   <= {avg2(r_u[0], r_u[1]), avg2(r_u[2], r_u[3])};
                        end
                        2'd2: begin
                            r_address <= VBase + r_c_off;
                            r_wdata   <= {avg2(r_v[0], r_v[1]), avg2(r_v[2], r_v[3])};
                        end
                        2'd3: begin
                            r_we_n <= 1'b1;
                            r_step <= '0;
                            if (r_group == LastGroup) begin
                                r_done  <= 1'b1;
                                r_state <= S_RGB_DONE;
                            end else begin
                                r_group   <= r_group + 18'd1;
                                r_rgb_ptr <= r_rgb_ptr + 18'd6;
                                r_address <= r_rgb_ptr + 18'd6;
                                r_y_ptr   <= r_y_ptr + 18'd2;
                                r_c_off   <= r_c_off + 18'd1;
                                r_state   <= S_RGB_READ;
                            end
                        end
                    endcase
                end
                S_RGB_DONE: begin
                    r_state <= S_RGB_IDLE;
                end
                default: begin
                    r_state <= S_RGB_IDLE;
                end
            endcase
        end
    end

    assign SRAM_address    = r_address;
    assign SRAM_write_data = r_wdata;
    assign SRAM_we_n       = r_we_n;
    assign Done            = r_done;

endmodule

// File: tb/tb_rgb_to_yuv_downsampler.sv
// Directed bench for rgb_to_yuv_downsampler with two groups per pass, a
// two-cycle-latency SRAM model and a write log checked against expected words.
module tb_rgb_to_yuv_downsampler;

    localparam int unsigned RgbBase = 100;
    localparam int unsigned YBase   = 0;
    localparam int unsigned UBase   = 40;
    localparam int unsigned VBase   = 60;
    localparam int unsigned NumPix  = 8;

    logic        Clock  = 1'b0;
    logic        Resetn = 1'b0;
    logic        Enable = 1'b0;
    logic        Done;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_read_data;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    logic [15:0] mem [0:262143];
    logic [15:0] r_p1;

    int checks   = 0;
    int failures = 0;

    int          wr_n   = 0;
    int          done_n = 0;
    int          max_rd = 0;
    logic [17:0] log_a [64];
    logic [15:0] log_d [64];

    always #5 Clock = ~Clock;

    rgb_to_yuv_downsampler #(
        .RGB_BASE   (RgbBase),
        .Y_BASE     (YBase),
        .U_BASE     (UBase),
        .V_BASE     (VBase),
        .NUM_PIXELS (NumPix)
    ) dut (
        .Clock           (Clock),
        .Resetn          (Resetn),
        .Enable          (Enable),
        .Done            (Done),
        .SRAM_address    (SRAM_address),
        .SRAM_read_data  (SRAM_read_data),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n)
    );

    always @(posedge Clock) begin
        r_p1           <= mem[SRAM_address];
        SRAM_read_data <= r_p1;
    end

    always @(negedge Clock) begin
        if (!SRAM_we_n) begin
            if (wr_n < 64) begin
                log_a[wr_n] = SRAM_address;
                log_d[wr_n] = SRAM_write_data;
            end
            wr_n++;
        end
        if (Done) done_n++;
        if (SRAM_we_n && SRAM_address >= 18'(RgbBase) && int'(SRAM_address) > max_rd)
            max_rd = int'(SRAM_address);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [95:0] g0, input logic [95:0] g1);
        logic [191:0] w;
        w = {g0, g1};
        for (int i = 0; i < 12; i++) mem[RgbBase + i] = w[191 - 16 * i -: 16];
    endtask

    // Pulse Enable, optionally pulse it again mid-run, and count cycles to Done.
    task automatic run(input bit extra_en, output int lat);
        @(negedge Clock);
        Enable = 1'b1;
        lat = 0;
        while (!Done && lat < 200) begin
            @(negedge Clock);
            lat++;
            Enable = (extra_en && lat == 10);
        end
        Enable = 1'b0;
        repeat (4) @(negedge Clock);
    endtask

    task automatic check_writes(input string name, input int base, input logic [127:0] exp_d);
        logic [17:0] ea;
        int g;
        for (int i = 0; i < 8; i++) begin
            g = i / 4;
            case (i % 4)
                0:       ea = 18'(YBase + 2 * g);
                1:       ea = 18'(YBase + 2 * g + 1);
                2:       ea = 18'(UBase + g);
                default: ea = 18'(VBase + g);
            endcase
            if (base + i < 64) begin
                check($sformatf("%s_wr%0d_addr", name, i), 32'(log_a[base + i]), 32'(ea));
                check($sformatf("%s_wr%0d_data", name, i), 32'(log_d[base + i]),
                      32'(exp_d[127 - 16 * i -: 16]));
            end else begin
                check($sformatf("%s_wr%0d_logged", name, i), 32'(base + i), 32'(63));
            end
        end
    endtask

    initial begin
        int lat1;
        int lat2;
        int wb;
        int db;
        int k;

        // Reset state
        repeat (2) @(negedge Clock);
        check("rst_we_n", 32'(SRAM_we_n), 32'd1);
        check("rst_addr", 32'(SRAM_address), 32'd0);
        check("rst_wdata", 32'(SRAM_write_data), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        Resetn = 1'b1;
        @(negedge Clock);

        // Pass 1: white group then black group
        load({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 96'd0);
        wb = wr_n;
        db = done_n;
        run(1'b0, lat1);
        check("p1_latency_ok", 32'(lat1 > 0 && lat1 <= 36), 32'd1);
        check("p1_done_count", 32'(done_n - db), 32'd1);
        check("p1_write_count", 32'(wr_n - wb), 32'd8);
        check("p1_max_read_addr", 32'(max_rd), 32'(RgbBase + 11));
        check_writes("p1", wb, {16'hEBEB, 16'hEBEB, 16'h8080, 16'h8080,
                                16'h1010, 16'h1010, 16'h8080, 16'h8080});

        // Pass 2: red/black pairs then green/blue pairs, with a stray Enable mid-run
        load({16'hFF00, 16'h0000, 16'h0000, 16'hFF00, 16'h0000, 16'h0000},
             {16'h00FF, 16'h0000, 16'h00FF, 16'h00FF, 16'h0000, 16'h00FF});
        wb = wr_n;
        db = done_n;
        run(1'b1, lat2);
        check("p2_latency_same", 32'(lat2), 32'(lat1));
        check("p2_done_count", 32'(done_n - db), 32'd1);
        check("p2_write_count", 32'(wr_n - wb), 32'd8);
        check_writes("p2", wb, {16'h5210, 16'h5210, 16'h6D6D, 16'hB8B8,
                                16'h9129, 16'h9129, 16'h9393, 16'h4848});

        // Pass 3: reset lands in the first write cycle of group 0
        load({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
             {16'hFF00, 16'h0000, 16'h0000, 16'hFF00, 16'h0000, 16'h0000});
        wb = wr_n;
        db = done_n;
        @(negedge Clock);
        Enable = 1'b1;
        @(negedge Clock);
        Enable = 1'b0;
        k = 0;
        while (SRAM_we_n && k < 100) begin
            @(negedge Clock);
            k++;
        end
        check("p3_reached_write", 32'(SRAM_we_n), 32'd0);
        #1 Resetn = 1'b0;
        #1;
        check("p3_abort_we_n", 32'(SRAM_we_n), 32'd1);
        check("p3_abort_addr", 32'(SRAM_address), 32'd0);
        repeat (3) @(negedge Clock);
        check("p3_abort_writes", 32'(wr_n - wb), 32'd1);
        check("p3_abort_no_done", 32'(done_n - db), 32'd0);
        Resetn = 1'b1;
        @(negedge Clock);
        wb = wr_n;
        db = done_n;
        run(1'b0, lat2);
        check("p3_latency_same", 32'(lat2), 32'(lat1));
        check("p3_done_count", 32'(done_n - db), 32'd1);
        check("p3_write_count", 32'(wr_n - wb), 32'd8);
        check_writes("p3", wb, {16'hEBEB, 16'hEBEB, 16'h8080, 16'h8080,
                                16'h5210, 16'h5210, 16'h6D6D, 16'hB8B8});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb_to_yuv_downsampler.md
Name: rgb_to_yuv_downsampler

Overview:
- Compression-side counterpart of the Milestone 1 YUV-to-RGB upsampler/converter.
- Reads packed 8-bit RGB pixels from external SRAM and converts each pixel to YUV.
- Downsamples U and V horizontally by 2 and writes the Y, U and V planes back to SRAM in the segment layout the decompressor consumes.
- Single SRAM master while enabled; started by a top-level FSM and reports completion with a Done pulse.

Parameters:
- RGB_BASE, 146944: word address of the first packed RGB word.
- Y_BASE, 0: word address of the Y plane.
- U_BASE, 38400: word address of the downsampled U plane.
- V_BASE, 57600: word address of the downsampled V plane.
- NUM_PIXELS, 76800: pixels to process; must be a multiple of 4. G = NUM_PIXELS/4 groups.

Ports:
- Clock  in  1  system clock; all logic is rising-edge.
- Resetn  in  1  asynchronous, active-low reset.
- Enable  in  1  start pulse; sampled only in S_RGB_IDLE.
- Done  out  1  one-cycle pulse when the last write has been issued.
- SRAM_address  out  18  word address.
- SRAM_read_data  in  16  read data, valid 2 cycles after the address is presented.
- SRAM_write_data  out  16  write data.
- SRAM_we_n  out  1  active-low write enable; 0 writes SRAM_write_data to SRAM_address that cycle.

Behaviour:
- Reset values: SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, Done=0, group counter=0, state=S_RGB_IDLE.
- Reset asserted mid-operation aborts immediately to these values; no write occurs after reset.
- Input format: 2 pixels per 3 words, 6 words per group g of 4 pixels, read from RGB_BASE+6g .. +6g+5.
  - Word 0 = {R0,G0}, word 1 = {B0,R1}, word 2 = {G1,B1}; pixels 2..3 follow the same pattern in words 3..5.
- Per pixel, signed 32-bit arithmetic with arithmetic right shift (floor):
  - Y = ((16843R + 33030G + 6423B + 32768) >>> 16) + 16
  - U = ((-9699R - 19071G + 28770B + 32768) >>> 16) + 128
  - V = ((28770R - 24117G - 4653B + 32768) >>> 16) + 128
  - Each result is clipped to [0,255].
- Downsampling per pixel pair (2k, 2k+1): Uds = (U(2k) + U(2k+1) + 1) >> 1; Vds uses the same rule. Unsigned 9-bit sum, 8-bit result.
- Writes per group, in this order:
  1. Y_BASE+2g ← {Y0,Y1}
  2. Y_BASE+2g+1 ← {Y2,Y3}
  3. U_BASE+g ← {Uds01,Uds23}
  4. V_BASE+g ← {Vds01,Vds23}
- States:
  - S_RGB_IDLE: wait for Enable=1, then clear the group counter and go to S_RGB_READ.
  - S_RGB_READ: 6 consecutive cycles issuing read addresses, we_n=1.
  - S_RGB_WAIT: 2 cycles draining read latency; all 6 words are latched into a 6x16 buffer.
  - S_RGB_COMPUTE: at most 4 cycles using the shared multipliers.
  - S_RGB_WRITE: 4 consecutive cycles with we_n=0.
    - Next state is S_RGB_READ if g < G-1, else S_RGB_DONE.
  - S_RGB_DONE: Done=1 for exactly one cycle, then S_RGB_IDLE.
- Throughput bound: ≤ 16 cycles per group; total latency from Enable to Done ≤ 16G+4 cycles.
- SRAM_we_n=1 in every state except S_RGB_WRITE.
- Enable while not in S_RGB_IDLE is ignored; Enable held high in S_RGB_IDLE after Done starts a new pass.
- The address counter never runs past RGB_BASE+6G-1 on reads or past the plane ends on writes.

Decomposition:
- Add the state enum rgb_to_yuv_state_type (S_RGB_IDLE … S_RGB_DONE) to the shared state header define_state.h.
- Put the coefficient and offset constants (16843, 33030, 6423, -9699, -19071, 28770, -24117, -4653, 32768, 16, 128) in the same shared package.
- One natural sub-module, yuv_pixel_converter: clipped Y/U/V for one RGB pixel, combinational or 1-cycle registered.
  - It reuses the existing three-product multiplier unit and is instantiated or time-shared inside the compute state.

Test Plan:
- NUM_PIXELS=4, all RGB words 0xFFFF (white) -> Y words 0xEBEB,0xEBEB; U word 0x8080; V word 0x8080; Done once.
- All RGB words 0x0000 (black) -> Y words 0x1010,0x1010; U=0x8080; V=0x8080.
- Words {0xFF00,0x0000,0x0000, 0xFF00,0x0000,0x0000} (red,black,red,black) -> Y 0x5210,0x5210; U 0x6D6D; V 0xB8B8.
- NUM_PIXELS=8 -> exactly 12 reads at RGB_BASE..+11 and 8 writes in group order; we_n never 0 outside write cycles; Done ≤ 36 cycles after Enable.
- Reset pulsed during S_RGB_WRITE of group 0 -> we_n=1 immediately, no Done; a subsequent Enable rewrites group 0 correctly.
- Enable pulsed again mid-run -> ignored: same write count and Done timing as a single run.
